// File: rtl/osc_csr_pkg.sv
// Shared definitions for the oscilloscope CSR bank: per-channel word offsets,
// global-block offsets, control-register reset values and the VERSION word.
// The ctrl_word() helper packs one channel's control fields into the
// register layout seen on the bus (all control words fit in 16 bits).
package osc_csr_pkg;

  // Per-channel word offsets (channel c starts at word c*8)
  localparam logic [2:0] OFF_FREQ = 3'd0;
  localparam logic [2:0] OFF_AMP  = 3'd1;
  localparam logic [2:0] OFF_DECI = 3'd2;
  localparam logic [2:0] OFF_TRIG = 3'd3;
  localparam logic [2:0] OFF_CTRL = 3'd4;
  localparam logic [2:0] OFF_HSH  = 3'd5;
  localparam logic [2:0] OFF_VSH  = 3'd6;

  // Global block offsets, relative to word NUM_CH*8
  localparam int G_STATUS  = 0;
  localparam int G_IRQ_EN  = 1;
  localparam int G_COMMIT  = 2;
  localparam int G_VERSION = 3;

  localparam logic [31:0] VERSION_BASE = 32'h0002_0000;

  typedef struct packed {
    logic [9:0] deci_rate;
    logic [7:0] trig_level;
    logic [7:0] trig_line;
    logic       trig_edge;
    logic       wave_run;
    logic [9:0] h_shift;
    logic [9:0] v_shift;
    logic [4:0] v_scale;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{
    deci_rate:  10'd2,
    trig_level: 8'd128,
    trig_line:  8'd148,
    trig_edge:  1'b0,
    wave_run:   1'b1,
    h_shift:    10'd0,
    v_shift:    10'd0,
    v_scale:    5'd0
  };

  // Bus view of a control word; non-control offsets read as zero here.
  function automatic logic [15:0] ctrl_word(input ctrl_t s, input logic [2:0] off);
    logic [15:0] w;
    w = '0;
    case (off)
      OFF_DECI: w[9:0]  = s.deci_rate;
      OFF_TRIG: w       = {s.trig_line, s.trig_level};
      OFF_CTRL: begin
        w[12:8] = s.v_scale;
        w[1]    = s.trig_edge;
        w[0]    = s.wave_run;
      end
      OFF_HSH:  w[9:0]  = s.h_shift;
      OFF_VSH:  w[9:0]  = s.v_shift;
      default:  w       = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/osc_csr_chan.sv
// One scope channel: shadow control registers (bus-written), live control
// registers (copied from shadow on apply) and the amplitude snapshot taken
// when FREQ is read so a FREQ/AMP read pair is coherent.
// Ports: wr_en/wr_off/wdata/be - shadow write (low 16 bits / 2 lanes suffice);
//        apply - copy shadow to live; snap_en - capture vpp/max/min;
//        rd_off/rdata - combinational read of this channel's word;
//        live - current live control fields.
module osc_csr_chan
  import osc_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_off,
  input  logic [15:0] wdata,
  input  logic [1:0]  be,
  input  logic        apply,
  input  logic        snap_en,
  input  logic [2:0]  rd_off,
  input  logic [19:0] ad_freq,
  input  logic [7:0]  ad_vpp,
  input  logic [7:0]  ad_max,
  input  logic [7:0]  ad_min,
  output logic [31:0] rdata,
  output ctrl_t       live
);

  ctrl_t       shadow;
  logic [23:0] snap;
  logic [15:0] mask, nw;

  // Byte-lane merge of the write data into the current shadow word
  assign mask = {{8{be[1]}}, {8{be[0]}}};
  assign nw   = (ctrl_word(shadow, wr_off) & ~mask) | (wdata & mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= CTRL_RST;
      live   <= CTRL_RST;
      snap   <= '0;
    end else begin
      // Apply uses the pre-write shadow when a write lands in the same cycle
      if (apply)   live <= shadow;
      if (snap_en) snap <= {ad_vpp, ad_max, ad_min};
      if (wr_en) begin
        case (wr_off)
          OFF_DECI: shadow.deci_rate <= nw[9:0];
          OFF_TRIG: begin
            shadow.trig_line  <= nw[15:8];
            shadow.trig_level <= nw[7:0];
          end
          OFF_CTRL: begin
            shadow.v_scale   <= nw[12:8];
            shadow.trig_edge <= nw[1];
            shadow.wave_run  <= nw[0];
          end
          OFF_HSH:  shadow.h_shift <= nw[9:0];
          OFF_VSH:  shadow.v_shift <= nw[9:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_off)
      OFF_FREQ: rdata = {12'd0, ad_freq};
      OFF_AMP:  rdata = {8'd0, snap};
      default:  rdata = {16'd0, ctrl_word(shadow, rd_off)};
    endcase
  end

endmodule

// File: rtl/osc_csr_bank.sv
// Oscilloscope CSR bank: Avalon-MM slave with 1-cycle read latency, NUM_CH
// channel blocks (shadow/live/snapshot) and a global block with STATUS
// (W1C meas_done + pending), IRQ_EN, COMMIT and VERSION.
// Ports: clk/rst_n; avalon_* slave; ad_*/meas_valid measurement inputs;
//        frame_sync apply pulse; flattened live control outputs; irq level.
module osc_csr_bank
  import osc_csr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 avalon_write,
  input  logic                 avalon_read,
  input  logic [ADDR_W-1:0]    avalon_address,
  input  logic [31:0]          avalon_writedata,
  input  logic [3:0]           avalon_byteenable,
  output logic [31:0]          avalon_readdata,
  output logic                 avalon_readdatavalid,
  input  logic [NUM_CH*20-1:0] ad_freq,
  input  logic [NUM_CH*8-1:0]  ad_vpp,
  input  logic [NUM_CH*8-1:0]  ad_max,
  input  logic [NUM_CH*8-1:0]  ad_min,
  input  logic [NUM_CH-1:0]    meas_valid,
  input  logic                 frame_sync,
  output logic [NUM_CH*10-1:0] deci_rate,
  output logic [NUM_CH*8-1:0]  trig_level,
  output logic [NUM_CH*8-1:0]  trig_line,
  output logic [NUM_CH-1:0]    trig_edge,
  output logic [NUM_CH-1:0]    wave_run,
  output logic [NUM_CH*10-1:0] h_shift,
  output logic [NUM_CH*10-1:0] v_shift,
  output logic [NUM_CH*5-1:0]  v_scale,
  output logic                 irq
);

  localparam logic [ADDR_W-1:0] G_ADDR = ADDR_W'(NUM_CH * 8);

  logic [ADDR_W-4:0] ch_idx;
  logic [2:0]        off;
  logic              in_ch, wr_ctrl, wr_status, wr_irq_en, commit, apply;
  logic [ADDR_W-1:0] g_off;
  logic [NUM_CH-1:0] meas_done, irq_en, w1c;
  logic              pending;
  logic [31:0]       rd_next;
  logic [31:0]       ch_rdata [NUM_CH];
  logic              unused_ok;

  assign ch_idx = avalon_address[ADDR_W-1:3];
  assign off    = avalon_address[2:0];
  assign in_ch  = avalon_address < G_ADDR;
  assign g_off  = avalon_address - G_ADDR;

  // Only offsets 2..6 are writable shadow registers
  assign wr_ctrl   = avalon_write && in_ch && (off >= OFF_DECI) && (off <= OFF_VSH);
  assign wr_status = avalon_write && !in_ch && (g_off == ADDR_W'(G_STATUS)) && avalon_byteenable[0];
  assign wr_irq_en = avalon_write && !in_ch && (g_off == ADDR_W'(G_IRQ_EN)) && avalon_byteenable[0];
  assign commit    = avalon_write && !in_ch && (g_off == ADDR_W'(G_COMMIT)) &&
                     avalon_byteenable[0] && avalon_writedata[0];
  assign apply     = frame_sync || commit;
  assign w1c       = wr_status ? avalon_writedata[NUM_CH-1:0] : '0;

  assign unused_ok = ^{avalon_writedata[31:16], avalon_byteenable[3:2]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ctrl_t live;
    logic  hit;
    assign hit = in_ch && (ch_idx == (ADDR_W-3)'(c));

    osc_csr_chan u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ctrl && hit),
      .wr_off  (off),
      .wdata   (avalon_writedata[15:0]),
      .be      (avalon_byteenable[1:0]),
      .apply   (apply),
      .snap_en (avalon_read && hit && (off == OFF_FREQ)),
      .rd_off  (off),
      .ad_freq (ad_freq[c*20 +: 20]),
      .ad_vpp  (ad_vpp[c*8 +: 8]),
      .ad_max  (ad_max[c*8 +: 8]),
      .ad_min  (ad_min[c*8 +: 8]),
      .rdata   (ch_rdata[c]),
      .live    (live)
    );

    assign deci_rate[c*10 +: 10] = live.deci_rate;
    assign trig_level[c*8 +: 8]  = live.trig_level;
    assign trig_line[c*8 +: 8]   = live.trig_line;
    assign trig_edge[c]          = live.trig_edge;
    assign wave_run[c]           = live.wave_run;
    assign h_shift[c*10 +: 10]   = live.h_shift;
    assign v_shift[c*10 +: 10]   = live.v_shift;
    assign v_scale[c*5 +: 5]     = live.v_scale;
  end

  // Read mux; unmapped, reserved and write-only words fall through to zero
  always_comb begin
    rd_next = '0;
    if (in_ch) begin
      for (int c = 0; c < NUM_CH; c++)
        if (ch_idx == (ADDR_W-3)'(c)) rd_next = ch_rdata[c];
    end else begin
      case (g_off)
        ADDR_W'(G_STATUS): begin
          rd_next[31]         = pending;
          rd_next[NUM_CH-1:0] = meas_done;
        end
        ADDR_W'(G_IRQ_EN):  rd_next[NUM_CH-1:0] = irq_en;
        ADDR_W'(G_VERSION): rd_next = VERSION_BASE | 32'(NUM_CH);
        default:            rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avalon_readdata      <= '0;
      avalon_readdatavalid <= 1'b0;
      meas_done            <= '0;
      irq_en               <= '0;
      pending              <= 1'b0;
      irq                  <= 1'b0;
    end else begin
      avalon_readdatavalid <= avalon_read;
      if (avalon_read) avalon_readdata <= rd_next;
      // A new measurement wins over a coincident clear
      meas_done <= (meas_done & ~w1c) | meas_valid;
      if (wr_irq_en) irq_en <= avalon_writedata[NUM_CH-1:0];
      // A shadow write coincident with apply leaves pending set
      if (wr_ctrl)    pending <= 1'b1;
      else if (apply) pending <= 1'b0;
      irq <= |(meas_done & irq_en);
    end
  end

endmodule

// File: tb/tb_osc_csr_bank.sv
module tb_osc_csr_bank;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 6;

  logic              clk = 0;
  logic              rst_n = 0;
  logic              avalon_write = 0, avalon_read = 0;
  logic [ADDR_W-1:0] avalon_address = '0;
  logic [31:0]       avalon_writedata = '0;
  logic [3:0]        avalon_byteenable = '0;
  logic [31:0]       avalon_readdata;
  logic              avalon_readdatavalid;
  logic [NUM_CH*20-1:0] ad_freq = '0;
  logic [NUM_CH*8-1:0]  ad_vpp = '0, ad_max = '0, ad_min = '0;
  logic [NUM_CH-1:0]    meas_valid = '0;
  logic                 frame_sync = 0;
  logic [NUM_CH*10-1:0] deci_rate, h_shift, v_shift;
  logic [NUM_CH*8-1:0]  trig_level, trig_line;
  logic [NUM_CH-1:0]    trig_edge, wave_run;
  logic [NUM_CH*5-1:0]  v_scale;
  logic                 irq;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  osc_csr_bank #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .avalon_write(avalon_write), .avalon_read(avalon_read),
    .avalon_address(avalon_address), .avalon_writedata(avalon_writedata),
    .avalon_byteenable(avalon_byteenable), .avalon_readdata(avalon_readdata),
    .avalon_readdatavalid(avalon_readdatavalid),
    .ad_freq(ad_freq), .ad_vpp(ad_vpp), .ad_max(ad_max), .ad_min(ad_min),
    .meas_valid(meas_valid), .frame_sync(frame_sync),
    .deci_rate(deci_rate), .trig_level(trig_level), .trig_line(trig_line),
    .trig_edge(trig_edge), .wave_run(wave_run), .h_shift(h_shift),
    .v_shift(v_shift), .v_scale(v_scale), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Single read; checks valid and data one cycle later
  task automatic rd(input string tag, input int addr, input logic [31:0] exp);
    @(negedge clk);
    avalon_read = 1; avalon_address = ADDR_W'(addr);
    @(negedge clk);
    avalon_read = 0;
    chk({tag, "_vld"}, {31'd0, avalon_readdatavalid}, 32'd1);
    chk(tag, avalon_readdata, exp);
  endtask

  task automatic wr(input int addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    avalon_write = 1; avalon_address = ADDR_W'(addr);
    avalon_writedata = data; avalon_byteenable = be;
    @(negedge clk);
    avalon_write = 0;
  endtask

  task automatic fsync();
    @(negedge clk);
    frame_sync = 1;
    @(negedge clk);
    frame_sync = 0;
  endtask

  initial begin
    // Reset state
    #12 rst_n = 1;
    @(negedge clk);
    chk("rst_rdv", {31'd0, avalon_readdatavalid}, 32'd0);
    chk("rst_rdata", avalon_readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_deci", {12'd0, deci_rate}, {12'd0, 10'd2, 10'd2});
    chk("rst_trig", {trig_line, trig_level}, 32'h9494_8080);
    chk("rst_run_edge", {28'd0, wave_run, trig_edge}, 32'h0000_000C);

    // Reset values over the bus
    rd("rd_ch0_deci", 2, 32'd2);
    rd("rd_ch1_trig", 11, 32'h0000_9480);

    // Byte-lane write, shadow only until frame_sync
    wr(11, 32'h0000_2040, 4'b0001);
    chk("bl_live_hold", {24'd0, trig_level[15:8]}, 32'd128);
    rd("bl_shadow", 11, 32'h0000_9440);
    rd("bl_pending", 16, 32'h8000_0000);
    fsync();
    chk("bl_live_lvl", {24'd0, trig_level[15:8]}, 32'd64);
    chk("bl_live_line", {24'd0, trig_line[15:8]}, 32'd148);
    rd("bl_pend_clr", 16, 32'h0000_0000);

    // Write coincident with frame_sync: apply takes the old shadow
    @(negedge clk);
    avalon_write = 1; avalon_address = 6'd2; avalon_writedata = 32'd8;
    avalon_byteenable = 4'hF; frame_sync = 1;
    @(negedge clk);
    avalon_write = 0; frame_sync = 0;
    chk("wf_deci_old", {22'd0, deci_rate[9:0]}, 32'd2);
    rd("wf_pending", 16, 32'h8000_0000);
    fsync();
    chk("wf_deci_new", {22'd0, deci_rate[9:0]}, 32'd8);

    // COMMIT apply, two-lane write
    wr(13, 32'hFFFF_FFFF, 4'b0011);
    chk("cm_hold", {22'd0, h_shift[19:10]}, 32'd0);
    wr(18, 32'd1, 4'b0001);
    chk("cm_apply", {22'd0, h_shift[19:10]}, 32'h3FF);
    rd("cm_pend", 16, 32'h0000_0000);

    // RO writes ignored, no pending
    wr(0, 32'hFFFF_FFFF, 4'hF);
    wr(19, 32'hFFFF_FFFF, 4'hF);
    rd("ro_pend", 16, 32'h0000_0000);
    rd("ro_ver", 19, 32'h0002_0002);

    // Unmapped / reserved / WO reads
    rd("rsv_ch0", 7, 32'd0);
    rd("wo_commit", 18, 32'd0);

    // Coherent FREQ/AMP snapshot
    ad_freq[19:0] = 20'h12345; ad_vpp[7:0] = 8'd10; ad_max[7:0] = 8'h90; ad_min[7:0] = 8'h20;
    rd("snap_freq", 0, 32'h0001_2345);
    ad_vpp[7:0] = 8'd50;
    rd("snap_amp", 1, 32'h000A_9020);
    rd("snap_amp2", 1, 32'h000A_9020);

    // IRQ path
    wr(17, 32'd1, 4'b0001);
    rd("irq_en_rd", 17, 32'd1);
    @(negedge clk); meas_valid = 2'b01;
    @(negedge clk); meas_valid = 2'b00;
    chk("irq_reg_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_set", {31'd0, irq}, 32'd1);
    @(negedge clk);
    avalon_write = 1; avalon_address = 6'd16; avalon_writedata = 32'd1;
    avalon_byteenable = 4'b0001; meas_valid = 2'b01;
    @(negedge clk);
    avalon_write = 0; meas_valid = 2'b00;
    rd("w1c_setwins", 16, 32'h0000_0001);
    chk("irq_stay", {31'd0, irq}, 32'd1);
    wr(16, 32'd1, 4'b0001);
    @(negedge clk);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    // Channel 1 without enable: status only
    @(negedge clk); meas_valid = 2'b10;
    @(negedge clk); meas_valid = 2'b00;
    @(negedge clk);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rd("st_ch1", 16, 32'h0000_0002);

    // Back-to-back reads, then hold
    @(negedge clk);
    avalon_read = 1; avalon_address = 6'd19;
    @(negedge clk);
    avalon_address = 6'd63;
    chk("b2b_vld0", {31'd0, avalon_readdatavalid}, 32'd1);
    chk("b2b_ver", avalon_readdata, 32'h0002_0002);
    @(negedge clk);
    avalon_read = 0;
    chk("b2b_vld1", {31'd0, avalon_readdatavalid}, 32'd1);
    chk("b2b_unmap", avalon_readdata, 32'd0);
    rd("pre_hold", 19, 32'h0002_0002);
    @(negedge clk);
    chk("hold_vld", {31'd0, avalon_readdatavalid}, 32'd0);
    chk("hold_data", avalon_readdata, 32'h0002_0002);

    // Simultaneous read and write: read sees pre-write value
    @(negedge clk);
    avalon_read = 1; avalon_write = 1; avalon_address = 6'd2;
    avalon_writedata = 32'd5; avalon_byteenable = 4'hF;
    @(negedge clk);
    avalon_read = 0; avalon_write = 0;
    chk("rw_old", avalon_readdata, 32'd8);
    rd("rw_new", 2, 32'd5);

    // Reset in the middle of a read
    @(negedge clk);
    avalon_read = 1; avalon_address = 6'd2;
    #2 rst_n = 0;
    #2 avalon_read = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mrst_rdv", {31'd0, avalon_readdatavalid}, 32'd0);
    chk("mrst_rdata", avalon_readdata, 32'd0);
    chk("mrst_deci", {12'd0, deci_rate}, {12'd0, 10'd2, 10'd2});
    chk("mrst_hsh", {12'd0, h_shift}, 32'd0);
    rd("mrst_status", 16, 32'd0);
    rd("mrst_irq_en", 17, 32'd0);
    rd("mrst_amp", 1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
